// File: rtl/fifo_cam.sv
// ----------------------------------------------------------------------------
// fifo_cam : single-clock FIFO between camera capture and frame-buffer load.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_cam #(
  parameter  int DATA_WIDTH = 17,
  parameter  int DEPTH      = 1024,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Data,
  input  logic                  WrEn,
  input  logic                  RdEn,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Empty,
  output logic                  Full,
  output logic [ADDR_WIDTH:0]   Count
);

  localparam logic [ADDR_WIDTH:0]   c_count_full = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_count_one  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one    = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, full_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic w_wr_ok;
  logic w_rd_ok;

  // Acceptance uses the registered flags, so an empty FIFO never falls through.
  assign w_wr_ok = WrEn & ~full_q;
  assign w_rd_ok = RdEn & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   count_d = count_q + c_count_one;
      2'b01:   count_d = count_q - c_count_one;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      mem_q[wr_ptr_q] <= Data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (w_wr_ok) begin
        wr_ptr_q <= wr_ptr_q + c_ptr_one;
      end
      if (w_rd_ok) begin
        rd_ptr_q  <= rd_ptr_q + c_ptr_one;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == c_count_full);
    end
  end

  assign Q     = rd_data_q;
  assign Empty = empty_q;
  assign Full  = full_q;
  assign Count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_cam.sv
// ----------------------------------------------------------------------------
// tb_fifo_cam : directed stimulus against a queue model of fifo_cam.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_cam;

  localparam int DW    = 17;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data;
  logic          wr_en;
  logic          rd_en;
  wire  [DW-1:0] q;
  wire           empty;
  wire           full;
  wire  [AW:0]   count;

  always #5 clk = ~clk;

  fifo_cam #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .Data  (data),
    .WrEn  (wr_en),
    .RdEn  (rd_en),
    .Q     (q),
    .Empty (empty),
    .Full  (full),
    .Count (count)
  );

  int            tests = 0;
  int            fails = 0;
  bit            chk_en = 1'b0;
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_out = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: an unbounded queue limited to DEPTH entries.
  task automatic tick(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
    bit wok;
    bit rok;
    reset = r;
    wr_en = w;
    rd_en = rd;
    data  = d;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_out  = '0;
      chk_en = 1'b1;
    end else begin
      wok = w && (mq.size() < DEPTH);
      rok = rd && (mq.size() > 0);
      if (rok) m_out = mq.pop_front();
      if (wok) mq.push_back(d);
    end
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("Q",     32'(q),     32'(m_out));
      check("Empty", 32'(empty), 32'(mq.size() == 0));
      check("Full",  32'(full),  32'(mq.size() == DEPTH));
      check("Count", 32'(count), 32'(mq.size()));
    end
  end

  initial begin
    int written;
    int cycles;
    bit w;
    bit r;

    // Reset and read-on-empty
    tick(1, 0, 0, '0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full),  0);
    check("rst_count", 32'(count), 0);
    check("rst_q",     32'(q),     0);
    tick(0, 0, 1, '0);
    check("rd_empty_q",     32'(q),     0);
    check("rd_empty_count", 32'(count), 0);

    // Frame burst: start marker plus 32 pixel words
    tick(0, 1, 0, 17'h10000);
    for (int i = 0; i < 32; i++) tick(0, 1, 0, {1'b0, 16'($urandom)});
    check("burst_count", 32'(count), 33);
    check("burst_full",  32'(full),  0);
    tick(0, 0, 1, '0);
    check("burst_first", 32'(q), 32'h10000);
    for (int i = 0; i < 32; i++) tick(0, 0, 1, '0);
    check("burst_empty", 32'(empty), 1);

    // Fill to full, drop the overflow write, drain
    for (int i = 0; i < DEPTH; i++) tick(0, 1, 0, DW'(i * 7 + 3));
    check("fill_full",  32'(full),  1);
    check("fill_count", 32'(count), 1024);
    tick(0, 1, 0, 17'h1ABCD);
    check("drop_count", 32'(count), 1024);
    tick(0, 0, 1, '0);
    check("fill_first", 32'(q), 3);
    check("fill_nfull", 32'(full), 0);
    for (int i = 1; i < DEPTH; i++) tick(0, 0, 1, '0);
    check("fill_last",  32'(q), 32'h1BFC);
    check("fill_empty", 32'(empty), 1);

    // Concurrent read/write at Count=10
    for (int i = 0; i < 10; i++) tick(0, 1, 0, DW'(100 + i));
    tick(0, 1, 1, DW'(200));
    check("conc_first", 32'(q), 100);
    for (int i = 1; i < 50; i++) tick(0, 1, 1, DW'(200 + i));
    check("conc_count", 32'(count), 10);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, '0);
    check("conc_last", 32'(q), 249);

    // Both on empty: only the write happens
    tick(0, 1, 1, 17'h00055);
    check("e_both_count", 32'(count), 1);
    check("e_both_q",     32'(q),     249);
    tick(0, 0, 1, '0);
    check("e_both_rd", 32'(q), 32'h55);

    // Both on full: only the read happens
    for (int i = 0; i < DEPTH; i++) tick(0, 1, 0, DW'(i));
    tick(0, 1, 1, 17'h1FFFF);
    check("f_both_count", 32'(count), 1023);
    check("f_both_full",  32'(full),  0);
    check("f_both_q",     32'(q),     0);
    for (int i = 1; i < DEPTH; i++) tick(0, 0, 1, '0);
    check("f_both_last", 32'(q), 1023);

    // Random-rate stream of 3000 words across many wraps
    written = 0;
    cycles  = 0;
    while ((written < 3000 || mq.size() > 0) && cycles < 20000) begin
      w = (written < 3000) && ($urandom_range(99) < 55);
      r = ($urandom_range(99) < 50);
      if (w && mq.size() < DEPTH) written++;
      tick(0, w, r, DW'($urandom));
      cycles++;
    end
    check("stream_done",  32'(cycles < 20000), 1);
    check("stream_empty", 32'(empty), 1);

    // Mid-operation reset with Count=5
    for (int i = 0; i < 6; i++) tick(0, 1, 0, DW'(32'h0AAA + i));
    tick(0, 0, 1, '0);
    check("mid_q",     32'(q),     32'h0AAA);
    check("mid_count", 32'(count), 5);
    tick(1, 0, 0, '0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_q",     32'(q),     0);
    tick(0, 1, 0, 17'h0F00D);
    tick(0, 0, 1, '0);
    check("mid_new_q",     32'(q),     32'h0F00D);
    check("mid_new_empty", 32'(empty), 1);
    tick(0, 0, 1, '0);
    check("mid_hold_q", 32'(q), 32'h0F00D);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_cam.md
Name: fifo_cam

Overview:
- Single-clock synchronous FIFO that buffers 17-bit camera words between the camera capture logic and the video/frame-buffer controller's load port.
- Bit 16 is a frame-start marker; the camera writes 17'h10000 as its start-frame command, followed by pixel words with bit 16 = 0.
- The FIFO is content-agnostic and treats all 17 bits as opaque data.
- Provides registered Empty/Full flags, a fill count, and one-cycle registered read data.

Parameters:
- DATA_WIDTH, 17, word width in bits.
- DEPTH, 1024, number of storage entries; must be a power of two and at least 64.
- ADDR_WIDTH, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Data  input  DATA_WIDTH  write data.
- WrEn  input  1  write request.
- RdEn  input  1  read request.
- Q  output  DATA_WIDTH  registered read data.
- Empty  output  1  FIFO holds no words.
- Full  output  1  FIFO holds DEPTH words.
- Count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH.

Behaviour:
- Reset:
  - Sampled on a rising clk edge while reset=1.
  - Write pointer, read pointer and Count go to 0; Q=0; Empty=1; Full=0.
  - Memory contents are don't-care.
  - Reset has priority over WrEn/RdEn in the same cycle.
  - Reset mid-operation discards all stored words.
- Write:
  - Accepted on an edge where WrEn=1 and Full=0, using the flag value before the edge.
  - Data is stored at the write pointer; the pointer increments modulo DEPTH.
  - A write while Full=1 is dropped silently; no state changes.
- Read:
  - Accepted on an edge where RdEn=1 and Empty=0, using the flag value before the edge.
  - Q loads the word at the read pointer on that same edge, so data is valid immediately after the edge (1-cycle latency from RdEn).
  - The read pointer increments modulo DEPTH.
  - A read while Empty=1 is ignored; Q holds its previous value.
- Q changes only on an accepted read or on reset.
- Simultaneous accepted read and write:
  - Both take effect; Count is unchanged.
  - When Empty=1 before the edge, only the write occurs (no fall-through).
  - When Full=1 before the edge, only the read occurs.
- Count:
  - +1 on write only, -1 on read only, unchanged otherwise.
- Flags:
  - Registered and consistent with Count after every edge: Empty = (Count==0), Full = (Count==DEPTH).
  - Empty deasserts in the cycle right after the first accepted write edge; the word is readable on the next edge.
  - Full asserts immediately after the edge accepting the DEPTH-th word.
  - Full deasserts immediately after the next accepted read.
- Wrap-around:
  - Pointers wrap from DEPTH-1 to 0 with no loss or reordering; strict FIFO order holds across any number of wraps.
- Storage:
  - Inferable RAM (synchronous write, registered read); no combinational path from Data to Q.

Test Plan:
- Reset: assert reset for 1 cycle -> Empty=1, Full=0, Count=0, Q=0. RdEn=1 on empty -> Q stays 0, Count stays 0.
- Frame burst:
  - Write 17'h10000, then 32 random 16-bit words with bit16=0, one per cycle -> Full never asserts, Count=33.
  - Then RdEn=1 for 33 cycles -> Q sequence equals the written sequence, each word valid the cycle after its RdEn edge; Empty=1 after the 33rd read.
- Fill to full:
  - Write 1024 words -> Full=1 after the 1024th write.
  - A 1025th write (value 17'h1ABCD) is dropped.
  - Reading all 1024 returns the original words only; Empty=1 at the end.
- Concurrent read/write: with Count=10, hold WrEn=RdEn=1 for 50 cycles -> Count stays 10; output order is preserved.
- Edge cases:
  - On empty, WrEn=RdEn=1 in the same cycle -> Count=1, Q unchanged.
  - On full, both asserted -> Count=1023, Full=0.
- Wrap and mid-op reset:
  - Stream 3000 words at random rates without overflow -> all read back in order.
  - Assert reset with Count=5 -> next cycle Empty=1, Count=0, Q=0; a subsequent write/read returns only the new word.
